gon_bus_arbiter: RTL and testbench
==================================

// Module: gon_bus_arbiter
// PURPOSE
//  Time-shares one GON bus among NUMS_REQ requesters (PE-row output drains / GLB write ports).
//  Each requester asks for a burst of req_len beats under req_tag; arbiter picks round-robin,
//  drives bus_tag so only the matching multicast controllers forward, counts beats, releases.
//  Sits between the PE-array control FSM and the GON bus tag input.
// PARAMETERS
//  NUMS_REQ   4             number of requesters
//  ID_SIZE    `XID_BITS     tag width, equals GON bus ID width
//  LEN_BITS   8             burst length counter width
//  IDLE_TAG   {ID_SIZE{1'b1}}  tag driven when no grant; config must never assign this ID
//  TIMEOUT    255           stall cycles before abort (only with GON_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1                   clock
//  rst          in   1                   asynchronous active-low reset
//  req          in   NUMS_REQ            request, held high until matching done pulse
//  req_tag      in   NUMS_REQ*ID_SIZE    per-requester tag, slice i = bits [ID_SIZE*(i+1)-1:ID_SIZE*i]
//  req_len      in   NUMS_REQ*LEN_BITS   per-requester beat count, same slicing
//  grant        out  NUMS_REQ            one-hot, high for whole burst
//  done         out  NUMS_REQ            one-hot 1-cycle pulse at burst end
//  bus_tag      out  ID_SIZE             tag to GON bus
//  bus_valid    in   1                   GON slave_valid (observed)
//  bus_ready    in   1                   GON slave_ready (observed)
//  beat_cnt     out  LEN_BITS            beats completed in current burst
//  busy         out  1                   state != IDLE
//  timeout_err  out  1                   sticky abort flag (tied 0 without macro)
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, grant=0, done=0, bus_tag=IDLE_TAG, beat_cnt=0, rr_ptr=0, busy=0, timeout_err=0.
//  Beat = bus_valid & bus_ready in XFER; all outputs registered.
//  FSM IDLE -> XFER -> DONE -> IDLE.
//   IDLE: if |req, winner = first set req at or after rr_ptr (wrapping); latch tag/len of winner;
//         next cycle grant[w]=1, bus_tag=req_tag[w], beat_cnt=0, rr_ptr=w+1 mod NUMS_REQ.
//   XFER: each beat beat_cnt++; beat making beat_cnt==len -> DONE next cycle.
//         len==0: XFER lasts exactly one cycle, no beats counted, then DONE.
//         Beats while beat_cnt==len (len 0) are ignored, not counted.
//   DONE: grant=0, done[w]=1 for one cycle, bus_tag=IDLE_TAG; -> IDLE.
//  Latency: req to grant 1 cycle; back-to-back bursts separated by DONE+IDLE = 2 idle-tag cycles.
//  Latched tag/len immune to req_tag/req_len changes during burst.
//  Dropping req[w] mid-burst ignored; burst completes. Requester in done cycle must drop or re-arbitrate.
//  Simultaneous requests: round-robin, no starvation; winner pointer advances only on grant.
//  beat_cnt saturates at 2^LEN_BITS-1 (never wraps).
//  Reset mid-burst: immediate return to reset values, no done pulse.
// CONFIGURATION
//  GON_ARB_TIMEOUT_EN defined: stall counter clears on each beat, increments in XFER otherwise;
//   reaching TIMEOUT -> DONE with done[w] pulse, timeout_err set (sticky until reset).
//  Undefined: no counter, XFER waits indefinitely, timeout_err tied 0, TIMEOUT unused.
// STRUCTURE
//  gon_pkg: gon_arb_state_e {ARB_IDLE, ARB_XFER, ARB_DONE}, GON_IDLE_TAG constant.
//  Sub-module rr_picker (req, ptr -> one-hot winner + index), purely combinational.
// TESTING
//  1 req[1], tag=5, len=3, bus handshakes every cycle -> grant[1] cycle 1, bus_tag=5, done[1] after 3rd beat, bus_tag back to IDLE_TAG.
//  2 req=4'b1111 held, len=1 each -> grant order 0,1,2,3,0; done spacing 3 cycles per burst.
//  3 len=0 on req[2] -> grant[2] for 1 cycle, done[2] next, beat_cnt stays 0.
//  4 len=4, bus_ready toggles 1010... -> exactly 4 beats counted, done after the 4th handshake only.
//  5 rst low mid-burst (beat_cnt=2) -> all outputs at reset values same cycle, no done pulse.
//  6 GON_ARB_TIMEOUT_EN, TIMEOUT=10, no beats -> done pulse after 10 stall cycles, timeout_err=1 sticky.

Source files
------------

// File: rtl/gon_pkg.sv
// Shared types and constants for the GON bus arbiter.
// XID_BITS sets the GON bus ID width; it falls back to 4 when the build does not define it.
`ifndef XID_BITS
`define XID_BITS 4
`endif

package gon_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_XFER = 2'd1,
    ARB_DONE = 2'd2
  } gon_arb_state_e;

  localparam int GON_ID_BITS = `XID_BITS;
  localparam logic [GON_ID_BITS-1:0] GON_IDLE_TAG = {GON_ID_BITS{1'b1}};

endpackage

// File: rtl/gon_bus_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or after ptr (wrapping), as one-hot and index.
module rr_picker #(
  parameter int NUMS_REQ = 4,
  parameter int PTR_W    = (NUMS_REQ > 1) ? $clog2(NUMS_REQ) : 1
) (
  input  logic [NUMS_REQ-1:0] req,
  input  logic [PTR_W-1:0]    ptr,
  output logic [NUMS_REQ-1:0] win_oh,
  output logic [PTR_W-1:0]    win_idx,
  output logic                found
);

  logic [PTR_W-1:0] k;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    k       = '0;
    for (int i = 0; i < NUMS_REQ; i++) begin
      k = PTR_W'((int'(ptr) + i) % NUMS_REQ);
      if (!found && req[k]) begin
        found      = 1'b1;
        win_oh[k]  = 1'b1;
        win_idx    = k;
      end
    end
  end

endmodule

// File: rtl/gon_bus_arbiter.sv
// Round-robin burst arbiter for one GON bus: grants a requester, drives its tag, counts beats.
// Optional stall abort is enabled by defining GON_ARB_TIMEOUT_EN.
module gon_bus_arbiter
  import gon_pkg::*;
#(
  parameter int                   NUMS_REQ = 4,
  parameter int                   ID_SIZE  = `XID_BITS,
  parameter int                   LEN_BITS = 8,
  parameter logic [ID_SIZE-1:0]   IDLE_TAG = {ID_SIZE{1'b1}},
  parameter int                   TIMEOUT  = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUMS_REQ-1:0]            req,
  input  logic [NUMS_REQ*ID_SIZE-1:0]    req_tag,
  input  logic [NUMS_REQ*LEN_BITS-1:0]   req_len,
  output logic [NUMS_REQ-1:0]            grant,
  output logic [NUMS_REQ-1:0]            done,
  output logic [ID_SIZE-1:0]             bus_tag,
  input  logic                           bus_valid,
  input  logic                           bus_ready,
  output logic [LEN_BITS-1:0]            beat_cnt,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int PTR_W = (NUMS_REQ > 1) ? $clog2(NUMS_REQ) : 1;

  gon_arb_state_e        state;
  logic [PTR_W-1:0]      rr_ptr;
  logic [LEN_BITS-1:0]   lat_len;

  logic [NUMS_REQ-1:0]   pick_oh;
  logic [PTR_W-1:0]      pick_idx;
  logic                  pick_found;
  logic [PTR_W-1:0]      ptr_next;

  logic                  beat;
  logic                  len_zero;
  logic [LEN_BITS-1:0]   cnt_next;
  logic                  beat_end;
  logic                  xfer_end;

  function automatic logic [LEN_BITS-1:0] sat_inc(input logic [LEN_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  rr_picker #(
    .NUMS_REQ (NUMS_REQ),
    .PTR_W    (PTR_W)
  ) u_picker (
    .req     (req),
    .ptr     (rr_ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .found   (pick_found)
  );

  assign ptr_next = (pick_idx == PTR_W'(NUMS_REQ - 1)) ? '0 : pick_idx + 1'b1;
  assign beat     = bus_valid & bus_ready;
  assign len_zero = (lat_len == '0);
  assign cnt_next = sat_inc(beat_cnt);
  assign beat_end = beat && !len_zero && (cnt_next == lat_len);

`ifdef GON_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  logic [STALL_W-1:0] stall_cnt;
  logic               stall_end;
  logic               timeout_err_r;

  assign stall_end   = !len_zero && !beat && (stall_cnt == STALL_W'(TIMEOUT - 1));
  assign xfer_end    = len_zero | beat_end | stall_end;
  assign timeout_err = timeout_err_r;

  // Stall counter restarts on every grant and every beat; the abort flag is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt     <= '0;
      timeout_err_r <= 1'b0;
    end else if (state == ARB_IDLE) begin
      stall_cnt <= '0;
    end else if (state == ARB_XFER) begin
      if (beat) stall_cnt <= '0;
      else      stall_cnt <= stall_cnt + 1'b1;
      if (stall_end) timeout_err_r <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg  = (TIMEOUT == 0);
  assign xfer_end    = len_zero | beat_end;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      done     <= '0;
      bus_tag  <= IDLE_TAG;
      beat_cnt <= '0;
      rr_ptr   <= '0;
      lat_len  <= '0;
      busy     <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            state    <= ARB_XFER;
            busy     <= 1'b1;
            grant    <= pick_oh;
            bus_tag  <= req_tag[pick_idx*ID_SIZE +: ID_SIZE];
            lat_len  <= req_len[pick_idx*LEN_BITS +: LEN_BITS];
            beat_cnt <= '0;
            rr_ptr   <= ptr_next;
          end
        end
        ARB_XFER: begin
          // Beats arriving on a zero-length burst are not counted.
          if (beat && !len_zero) beat_cnt <= cnt_next;
          if (xfer_end) begin
            state   <= ARB_DONE;
            grant   <= '0;
            done    <= grant;
            bus_tag <= IDLE_TAG;
          end
        end
        ARB_DONE: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gon_bus_arbiter.sv
// Scoreboard bench for gon_bus_arbiter: stimulus queues expected grant/done events, a monitor pops them.
module tb_gon_bus_arbiter;

  localparam int N   = 4;
  localparam int IDW = 4;
  localparam int LB  = 8;
  localparam int TO  = 10;
  localparam int IDLE_T = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*IDW-1:0] req_tag;
  logic [N*LB-1:0] req_len;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic [IDW-1:0]  bus_tag;
  logic            bus_valid;
  logic            bus_ready;
  logic [LB-1:0]   beat_cnt;
  logic            busy;
  logic            timeout_err;

  gon_bus_arbiter #(
    .NUMS_REQ (N),
    .ID_SIZE  (IDW),
    .LEN_BITS (LB),
    .IDLE_TAG (4'hF),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_tag     (req_tag),
    .req_len     (req_len),
    .grant       (grant),
    .done        (done),
    .bus_tag     (bus_tag),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .beat_cnt    (beat_cnt),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int idx;
    int tag;
    int beats;
    int at;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_g(input int idx, input int tag, input int at);
    exp_t e;
    e.is_done = 1'b0; e.idx = idx; e.tag = tag; e.beats = 0; e.at = at;
    sb.push_back(e);
  endtask

  task automatic push_d(input int idx, input int beats, input int at);
    exp_t e;
    e.is_done = 1'b1; e.idx = idx; e.tag = IDLE_T; e.beats = beats; e.at = at;
    sb.push_back(e);
  endtask

  // Monitor: a grant rising edge or a done pulse consumes the next expected event.
  logic [N-1:0] grant_q = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (grant != '0 && grant_q == '0) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_grant: got grant=%b, expected no event", grant);
        end else begin
          e = sb.pop_front();
          check("grant_kind", int'(e.is_done), 0);
          check("grant_onehot", int'(grant), 1 << e.idx);
          check("grant_tag", int'(bus_tag), e.tag);
          check("grant_cycle", cyc, e.at);
        end
      end
      if (done != '0) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done: got done=%b, expected no event", done);
        end else begin
          e = sb.pop_front();
          check("done_kind", int'(e.is_done), 1);
          check("done_onehot", int'(done), 1 << e.idx);
          check("done_tag_idle", int'(bus_tag), e.tag);
          check("done_grant_low", int'(grant), 0);
          check("done_beats", int'(beat_cnt), e.beats);
          check("done_cycle", cyc, e.at);
        end
      end
    end
    grant_q <= grant;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int tag, input int len);
    req_tag[i*IDW +: IDW] = IDW'(tag);
    req_len[i*LB +: LB]   = LB'(len);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    bus_valid = 1'b0;
    bus_ready = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, int'(grant), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_bus_tag"}, int'(bus_tag), IDLE_T);
    check({tag, "_beat_cnt"}, int'(beat_cnt), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_timeout_err"}, int'(timeout_err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    rst = 1'b0;
    req = '0;
    req_tag = '0;
    req_len = '0;
    bus_valid = 1'b0;
    bus_ready = 1'b0;
    tick(2);
    check_reset_outputs("rst");
    rst = 1'b1;
    tick(1);

    // Single burst, len 3, handshake every cycle.
    bus_valid = 1'b1; bus_ready = 1'b1;
    set_req(1, 5, 3);
    c = cyc;
    req = 4'b0010;
    push_g(1, 5, c + 1);
    push_d(1, 3, c + 4);
    tick(2);
    check("t1_beat_mid", int'(beat_cnt), 1);
    tick(2);
    req = '0;
    tick(2);
    check("t1_busy_after", int'(busy), 0);
    check("t1_tag_after", int'(bus_tag), IDLE_T);

    // All four requesting, len 1: round-robin 0,1,2,3,0 every 3 cycles.
    do_reset();
    bus_valid = 1'b1; bus_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 8 + i, 1);
    c = cyc;
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      push_g(k % N, 8 + (k % N), c + 1 + 3 * k);
      push_d(k % N, 1, c + 2 + 3 * k);
    end
    tick(14);
    req = '0;
    tick(3);

    // Zero-length burst with beats on the bus: none counted.
    do_reset();
    bus_valid = 1'b1; bus_ready = 1'b1;
    set_req(2, 6, 0);
    c = cyc;
    req = 4'b0100;
    push_g(2, 6, c + 1);
    push_d(2, 0, c + 2);
    tick(2);
    req = '0;
    check("t3_beat_cnt", int'(beat_cnt), 0);
    tick(2);

    // len 4 with bus_ready alternating; tag/len change mid-burst must be ignored.
    do_reset();
    bus_valid = 1'b1; bus_ready = 1'b0;
    set_req(0, 3, 4);
    c = cyc;
    req = 4'b0001;
    push_g(0, 3, c + 1);
    push_d(0, 4, c + 8);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      bus_ready = (k % 2 == 1);
      if (k == 2) set_req(0, 9, 1);
    end
    req = '0;
    tick(3);

    // Reset mid-burst: outputs return to reset values at once, no done pulse.
    do_reset();
    bus_valid = 1'b1; bus_ready = 1'b1;
    set_req(0, 7, 5);
    c = cyc;
    req = 4'b0001;
    push_g(0, 7, c + 1);
    tick(3);
    check("t5_beat_cnt_before", int'(beat_cnt), 2);
    check("t5_busy_before", int'(busy), 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("t5");
    req = '0;
    tick(2);
    rst = 1'b1;
    tick(3);
    check("t5_busy_after", int'(busy), 0);

    // Stalled burst: no beats at all.
    do_reset();
    bus_valid = 1'b0; bus_ready = 1'b0;
    set_req(3, 4, 2);
    c = cyc;
    req = 4'b1000;
    push_g(3, 4, c + 1);
`ifdef GON_ARB_TIMEOUT_EN
    push_d(3, 0, c + 1 + TO);
    tick(1 + TO);
    req = '0;
    check("t6_timeout_err", int'(timeout_err), 1);
    tick(5);
    check("t6_timeout_sticky", int'(timeout_err), 1);
    check("t6_busy_after", int'(busy), 0);
`else
    tick(20);
    check("t6_still_busy", int'(busy), 1);
    check("t6_grant_held", int'(grant), 8);
    check("t6_no_timeout", int'(timeout_err), 0);
`endif
    do_reset();

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
